// File: rtl/alu_pkg.sv
// Shared constants and operation encoding for the RV64 integer ALU and the
// branch unit that reuses its comparator.
package alu_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_func_e;

  // Only the low SHAMT_W bits of operand B steer the shifter.
  function automatic logic [SHAMT_W-1:0] shamt_of(input logic [XLEN-1:0] b);
    return b[SHAMT_W-1:0];
  endfunction

endpackage

// File: rtl/alu_comparator.sv
// Magnitude/equality comparator producing branch flags; shared with the
// branch unit so every operation code sees valid flags.
module alu_comparator
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lu,
  output logic            ls
);

  logic sign_differs;

  assign sign_differs = a[XLEN-1] ^ b[XLEN-1];
  assign eq = (a == b);
  assign lu = (a < b);
  // With differing signs the negative operand is the smaller one.
  assign ls = sign_differs ? a[XLEN-1] : lu;

endmodule

// File: rtl/alu.sv
// RV64 execute-stage ALU: combinational result/flags plus a one-cycle
// registered copy qualified by valid_q.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func,
  input  logic            sub_sra,
  input  logic            valid_in,
  output logic [XLEN-1:0] s,
  output logic            eq,
  output logic            lu,
  output logic            ls,
  output logic [XLEN-1:0] s_q,
  output logic            eq_q,
  output logic            lu_q,
  output logic            ls_q,
  output logic            valid_q
);

  alu_func_e          op;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    b_eff;
  logic [XLEN-1:0]    sum;
  logic [XLEN-1:0]    shl;
  logic [XLEN-1:0]    shr;

  assign op    = alu_func_e'(func);
  assign shamt = shamt_of(b);

  alu_comparator u_cmp (
    .a  (a),
    .b  (b),
    .eq (eq),
    .lu (lu),
    .ls (ls)
  );

  // Subtract as a + ~b + 1 so one adder serves both directions.
  assign b_eff = sub_sra ? ~b : b;
  assign sum   = a + b_eff + {{(XLEN-1){1'b0}}, sub_sra};

  assign shl = a << shamt;
  assign shr = sub_sra ? XLEN'($signed(a) >>> shamt) : (a >> shamt);

  always_comb begin
    s = '0;
    unique case (op)
      ADD_SUB: s = sum;
      SLL:     s = shl;
      SLT:     s = {{(XLEN-1){1'b0}}, ls};
      SLTU:    s = {{(XLEN-1){1'b0}}, lu};
      XOR:     s = a ^ b;
      SRL_SRA: s = shr;
      OR:      s = a | b;
      AND:     s = a & b;
    endcase
  end

  // valid_q marks the registered data as meaningful; there is no ready, the
  // data registers load every cycle and a consumer samples them only when
  // valid_q is high. Reset drops whatever was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      eq_q    <= 1'b0;
      lu_q    <= 1'b0;
      ls_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s;
      eq_q    <= eq;
      lu_q    <= lu;
      ls_q    <= ls;
      valid_q <= valid_in;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, registered path with reset,
// and a randomized sweep against a behavioural model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  func;
  logic        sub_sra;
  logic        valid_in;
  logic [63:0] s;
  logic        eq;
  logic        lu;
  logic        ls;
  logic [63:0] s_q;
  logic        eq_q;
  logic        lu_q;
  logic        ls_q;
  logic        valid_q;

  int total;
  int bad;
  logic [67:0] exp_q[$];

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .func     (func),
    .sub_sra  (sub_sra),
    .valid_in (valid_in),
    .s        (s),
    .eq       (eq),
    .lu       (lu),
    .ls       (ls),
    .s_q      (s_q),
    .eq_q     (eq_q),
    .lu_q     (lu_q),
    .ls_q     (ls_q),
    .valid_q  (valid_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_s(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic [2:0] mf, input logic msub);
    int unsigned sh;
    logic [63:0] fill;
    sh = mb % 64;
    case (mf)
      3'd0: return msub ? ma - mb : ma + mb;
      3'd1: return ma << sh;
      3'd2: return ($signed(ma) < $signed(mb)) ? 64'd1 : 64'd0;
      3'd3: return (ma < mb) ? 64'd1 : 64'd0;
      3'd4: return ma ^ mb;
      3'd5: begin
        fill = (msub && ma[63]) ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0;
        return (ma >> sh) | fill;
      end
      3'd6: return ma | mb;
      default: return ma & mb;
    endcase
  endfunction

  function automatic logic [2:0] model_flags(input logic [63:0] ma, input logic [63:0] mb);
    logic feq, flu, fls;
    feq = (ma == mb);
    flu = (ma < mb);
    fls = ($signed(ma) < $signed(mb));
    return {fls, flu, feq};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [63:0] da, input logic [63:0] db,
                       input logic [2:0] df, input logic dsub);
    a = da;
    b = db;
    func = df;
    sub_sra = dsub;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b1;
    drive(64'd5, 64'd3, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if ({s_q, eq_q, lu_q, ls_q, valid_q} !== 68'd0) begin
      bad++;
      $display("FAIL reset_regs: got s_q=%h flags=%b%b%b valid_q=%b want all zero",
               s_q, eq_q, lu_q, ls_q, valid_q);
    end
    total++;
    if (s !== 64'd8) begin
      bad++;
      $display("FAIL reset_comb: got s=%h want 8", s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [63:0] va[3] = '{64'd5, 64'd5, 64'd0};
    logic [63:0] vb[3] = '{64'd3, 64'd3, 64'd1};
    logic        vs[3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] ve[3] = '{64'h8, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 3'd0, vs[i]);
      total++;
      if (s !== ve[i]) begin
        bad++;
        $display("FAIL add_sub[%0d]: got %h want %h", i, s, ve[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [2:0]  vf[4] = '{3'd1, 3'd5, 3'd5, 3'd1};
    logic        vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] ve[4] = '{64'h0000_0000_0000_0100, 64'h0800_0000_0000_0001,
                           64'hF800_0000_0000_0001, 64'h0000_0000_0000_0100};
    logic [63:0] sa;
    sa = 64'h8000_0000_0000_0010;
    for (int i = 0; i < 4; i++) begin
      drive(sa, 64'h44, vf[i], vs[i]);
      total++;
      if (s !== ve[i]) begin
        bad++;
        $display("FAIL shift[%0d]: got %h want %h", i, s, ve[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(sa, 64'hFFFF_0000_0000_0000 << (i * 4), (i == 0) ? 3'd1 : 3'd5, i == 2);
      total++;
      if (s !== sa) begin
        bad++;
        $display("FAIL shift_zero[%0d]: got %h want %h", i, s, sa);
      end
    end
    drive(sa, 64'd63, 3'd5, 1'b1);
    total++;
    if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL shift_max_sra: got %h want all ones", s);
    end
    drive(sa, 64'd63, 3'd5, 1'b0);
    total++;
    if (s !== 64'd1) begin
      bad++;
      $display("FAIL shift_max_srl: got %h want 1", s);
    end
  endtask

  task automatic test_compare();
    for (int k = 0; k < 2; k++) begin
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd2, k[0]);
      total++;
      if ({eq, lu, ls} !== 3'b001 || s !== 64'd1) begin
        bad++;
        $display("FAIL slt[%0d]: got eq/lu/ls=%b%b%b s=%h want 001 s=1", k, eq, lu, ls, s);
      end
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd3, k[0]);
      total++;
      if (s !== 64'd0) begin
        bad++;
        $display("FAIL sltu[%0d]: got s=%h want 0", k, s);
      end
    end
    drive(64'h1234, 64'h1234, 3'd4, 1'b0);
    total++;
    if ({eq, lu, ls} !== 3'b100) begin
      bad++;
      $display("FAIL cmp_equal: got eq/lu/ls=%b%b%b want 100", eq, lu, ls);
    end
  endtask

  task automatic test_logic();
    logic [2:0]  vf[3] = '{3'd4, 3'd6, 3'd7};
    logic [63:0] ve[3] = '{64'hFF00, 64'hFFF0, 64'h00F0};
    for (int i = 0; i < 3; i++) begin
      drive(64'hF0F0, 64'h0FF0, vf[i], i == 1);
      total++;
      if (s !== ve[i]) begin
        bad++;
        $display("FAIL logic[%0d]: got %h want %h", i, s, ve[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    valid_in = 1'b1;
    drive(64'd5, 64'd3, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (s_q !== 64'd8 || valid_q !== 1'b1 || {eq_q, lu_q, ls_q} !== 3'b000) begin
      bad++;
      $display("FAIL reg_load: got s_q=%h valid_q=%b flags=%b%b%b want 8/1/000",
               s_q, valid_q, eq_q, lu_q, ls_q);
    end
    // Reset between edges while a result is held.
    drive(64'd1, 64'd2, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_q, eq_q, lu_q, ls_q, valid_q} !== 68'd0) begin
      bad++;
      $display("FAIL reg_async_reset: got s_q=%h flags=%b%b%b valid_q=%b want zero",
               s_q, eq_q, lu_q, ls_q, valid_q);
    end
    total++;
    if (s !== 64'd3 || {eq, lu, ls} !== 3'b011) begin
      bad++;
      $display("FAIL comb_in_reset: got s=%h flags=%b%b%b want 3/011", s, eq, lu, ls);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] ra, rb, es;
    logic [2:0]  ef, rf;
    logic        rs, rv;
    logic [67:0] got, want;
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = {ra[63:32], $urandom};
        2: rb = {~ra[63], ra[62:0]};
        default: ;
      endcase
      rf = 3'(i % 8);
      rs = 1'((i / 8) % 2);
      rv = 1'($urandom_range(0, 1));
      valid_in = rv;
      drive(ra, rb, rf, rs);
      es = model_s(ra, rb, rf, rs);
      ef = model_flags(ra, rb);
      total++;
      if (s !== es || {ls, lu, eq} !== ef) begin
        bad++;
        $display("FAIL rand_comb[%0d] f=%0d sub=%b a=%h b=%h: got s=%h lse=%b%b%b want s=%h lse=%b",
                 i, rf, rs, ra, rb, s, ls, lu, eq, es, ef);
      end
      exp_q.push_back({rv, ef, es});
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got = {valid_q, ls_q, lu_q, eq_q, s_q};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rand_reg[%0d]: got %h want %h", i, got, want);
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    a = '0;
    b = '0;
    func = '0;
    sub_sra = 1'b0;
    test_reset();
    test_add_sub();
    test_shifts();
    test_compare();
    test_logic();
    test_registered();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 64-bit integer ALU for the RV64 execute stage.
- Performs add/sub, shifts, logic ops and set-less-than, selected by a 3-bit funct3-style code plus a sub/sra modifier.
- Always produces three comparison flags (equal, less-unsigned, less-signed) for branch resolution.
- Result and flags are available combinationally; a registered copy with valid tracking is also provided for pipelined consumers.

Parameters:
- XLEN, 64, operand/result width. Shift amount is log2(XLEN) = 6 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2 or immediate)
- func  in  3  operation select
- sub_sra  in  1  modifier: subtract for func 000, arithmetic shift for func 101
- valid_in  in  1  qualifies a/b/func for the registered path
- s  out  XLEN  combinational result
- eq  out  1  combinational, a == b
- lu  out  1  combinational, a < b unsigned
- ls  out  1  combinational, a < b signed (two's complement)
- s_q  out  XLEN  registered s
- eq_q, lu_q, ls_q  out  1 each  registered flags
- valid_q  out  1  registered valid_in

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Combinational path (s, eq, lu, ls) has zero latency, is independent of clk/rst_n, and settles from a, b, func and sub_sra alone.
- func decode:
  - 000: s = a + b when sub_sra=0; s = a - b when sub_sra=1. Modulo 2^64, carry/overflow discarded.
  - 001: s = a << b[5:0] (logical left). sub_sra ignored.
  - 010: s = {63'b0, ls} (signed SLT). Valid for either sub_sra value.
  - 011: s = {63'b0, lu} (unsigned SLTU). Valid for either sub_sra value.
  - 100: s = a ^ b.
  - 101: s = a >> b[5:0] when sub_sra=0 (logical, zero fill). When sub_sra=1, arithmetic: fill with a[63].
  - 110: s = a | b.
  - 111: s = a & b.
- Shift amounts: b[63:6] always ignored. A shift of 0 returns a unchanged. A shift of 63 is the maximum.
- Flags are computed by a dedicated comparator and are valid for every func/sub_sra combination, not only during subtract.
  - eq = (a == b).
  - lu = a < b unsigned.
  - ls = a < b signed. When a[63] != b[63], ls = a[63].
- Registered path: on each rising clk, s_q/eq_q/lu_q/ls_q capture the combinational values and valid_q <= valid_in. Latency is 1 cycle. Data registers load every cycle regardless of valid_in; consumers qualify them with valid_q.
- Reset: rst_n low asynchronously forces s_q=0, eq_q=0, lu_q=0, ls_q=0, valid_q=0, held until rst_n rises. Reset asserted mid-operation drops the in-flight result (valid_q=0). The combinational outputs are unaffected by reset.
- No X propagation: every func code is defined, so no default-to-X branch is allowed.

Decomposition:
- Shared package alu_pkg:
  - XLEN and SHAMT_W constants.
  - Enum alu_func_e: ADD_SUB=3'b000, SLL=3'b001, SLT=3'b010, SLTU=3'b011, XOR=3'b100, SRL_SRA=3'b101, OR=3'b110, AND=3'b111.
- One sub-module: alu_comparator (a, b -> eq, lu, ls), reused by the branch unit.
- Adder, shifter and logic ops stay inline in alu.

Test Plan:
- ADD/SUB: a=64'h0000_0000_0000_0005, b=64'h3. sub_sra=0, func=000 -> s=64'h8. sub_sra=1 -> s=64'h2. a=0, b=1, sub_sra=1 -> s=64'hFFFF_FFFF_FFFF_FFFF (wrap).
- Shifts: a=64'h8000_0000_0000_0010, b=64'h44 (shamt 4). func=001 -> s=64'h0000_0000_0000_0100. func=101, sub_sra=0 -> s=64'h0800_0000_0000_0001. func=101, sub_sra=1 -> s=64'hF800_0000_0000_0001. b=0 -> s=a.
- Compare: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1 -> eq=0, lu=0, ls=1. func=010 -> s=1; func=011 -> s=0, for both sub_sra values. a=b=64'h1234 -> eq=1, lu=0, ls=0.
- Logic: a=64'hF0F0, b=64'h0FF0. func=100 -> 64'hFF00; func=110 -> 64'hFFF0; func=111 -> 64'h00F0.
- Registered path: drive a=5, b=3, func=000, valid_in=1 before a clk edge -> after the edge s_q=8, valid_q=1. Assert rst_n=0 between edges -> s_q, flags and valid_q go 0 immediately.
- Random sweep: 1000 random a/b over all 16 func/sub_sra combinations -> s and flags match the reference model above with zero mismatches.
